// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 2-to-4 decoder select path among four requesters.
// Optional hold-timer pre-emption is compiled in with `define ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       sel_en,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("decoder_rr_arbiter: HOLD_MAX must be in 2..255");
  end

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       sel_en_q, sel_en_d;
  logic       busy_q, busy_d;
  logic [1:0] last_q, last_d;
  logic       win_vld;
  logic [1:0] win_idx;
  logic       timeout;

  // First set request scanning from last+1, wrapping modulo 4.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] cand;
      cand = last_q + 2'(i);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       preempt_q, preempt_d;

  assign timeout = (cnt_q == HOLD_LAST) && |(req & ~gnt_q);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    sel_en_d = sel_en_q;
    last_d   = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win_vld) begin
          state_d  = ST_GRANT;
          gnt_d    = 4'b0001 << win_idx;
          sel_d    = win_idx;
          sel_en_d = 1'b1;
          last_d   = win_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = 8'd0;
`endif
        end else begin
          state_d  = ST_IDLE;
          gnt_d    = 4'b0000;
          sel_en_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!req[sel_q] || timeout) begin
          // sel keeps the old owner's index through the dead cycle.
          state_d  = ST_GAP;
          gnt_d    = 4'b0000;
          sel_en_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          preempt_d = req[sel_q];
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (cnt_q != HOLD_LAST) cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = 4'b0000;
        sel_en_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 4'b0000;
      sel_q    <= 2'd0;
      sel_en_q <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 2'd3;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      sel_en_q <= sel_en_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      preempt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign sel_en = sel_en_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter: vector table, rotation, pre-emption,
// asynchronous reset and uncontended-hold sequences, checked through a scoreboard queue.
module tb_decoder_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sel_en;
    logic       busy;
    logic       preempt;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    exp_t       exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       sel_en;
  logic       busy;
  logic       preempt;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  decoder_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .sel_en  (sel_en),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t e(input logic [3:0] g, input logic [1:0] s,
                             input logic en, input logic b, input logic p);
    e = '{gnt: g, sel: s, sel_en: en, busy: b, preempt: p};
  endfunction

  function automatic exp_t outs();
    outs = '{gnt: gnt, sel: sel, sel_en: sel_en, busy: busy, preempt: preempt};
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%b sel_en=%b busy=%b preempt=%b, want gnt=%b sel=%b sel_en=%b busy=%b preempt=%b",
               name, act.gnt, act.sel, act.sel_en, act.busy, act.preempt,
               want.gnt, want.sel, want.sel_en, want.busy, want.preempt);
    end
  endtask

  // Called at a falling edge: drive req, expect the result of the next rising edge.
  task automatic step(input logic [3:0] r, input exp_t want, input string name);
    exp_t got;
    req = r;
    sb.push_back(want);
    @(posedge clk);
    #1;
    got = outs();
    check(name, got, sb.pop_front());
    @(negedge clk);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{4'b0000, e(4'b0000, 2'd0, 0, 0, 0)};
    vecs[1]  = '{4'b0100, e(4'b0100, 2'd2, 1, 1, 0)};
    vecs[2]  = '{4'b0100, e(4'b0100, 2'd2, 1, 1, 0)};
    vecs[3]  = '{4'b0000, e(4'b0000, 2'd2, 0, 1, 0)};
    vecs[4]  = '{4'b0000, e(4'b0000, 2'd2, 0, 0, 0)};
    vecs[5]  = '{4'b1011, e(4'b1000, 2'd3, 1, 1, 0)};
    vecs[6]  = '{4'b1011, e(4'b1000, 2'd3, 1, 1, 0)};
    vecs[7]  = '{4'b0011, e(4'b0000, 2'd3, 0, 1, 0)};
    vecs[8]  = '{4'b0011, e(4'b0001, 2'd0, 1, 1, 0)};
    vecs[9]  = '{4'b0010, e(4'b0000, 2'd0, 0, 1, 0)};
    vecs[10] = '{4'b0010, e(4'b0010, 2'd1, 1, 1, 0)};
    vecs[11] = '{4'b0110, e(4'b0010, 2'd1, 1, 1, 0)};
    vecs[12] = '{4'b0100, e(4'b0000, 2'd1, 0, 1, 0)};
    vecs[13] = '{4'b0100, e(4'b0100, 2'd2, 1, 1, 0)};
    vecs[14] = '{4'b0000, e(4'b0000, 2'd2, 0, 1, 0)};
    vecs[15] = '{4'b0000, e(4'b0000, 2'd2, 0, 0, 0)};

    // Reset held with every requester asking.
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (2) @(negedge clk);
    check("reset_values", outs(), e(4'b0000, 2'd0, 0, 0, 0));
    rst_n = 1'b1;

    // Rotation 0,1,2,3,0 with one dead cycle between owners.
    for (int k = 0; k < 5; k++) begin
      logic [1:0] o;
      logic [3:0] oh;
      o  = 2'(k % 4);
      oh = 4'b0001 << o;
      step(4'b1111, e(oh, o, 1, 1, 0), $sformatf("rot%0d_grant", k));
      step(4'b1111, e(oh, o, 1, 1, 0), $sformatf("rot%0d_hold1", k));
      step(4'b1111, e(oh, o, 1, 1, 0), $sformatf("rot%0d_hold2", k));
      if (k < 4)
        step(4'b1111 & ~oh, e(4'b0000, o, 0, 1, 0), $sformatf("rot%0d_gap", k));
    end
    step(4'b0000, e(4'b0000, 2'd0, 0, 1, 0), "rot_end_gap");
    step(4'b0000, e(4'b0000, 2'd0, 0, 0, 0), "rot_end_idle");

    for (int i = 0; i < 16; i++)
      step(vecs[i].req, vecs[i].exp, $sformatf("vec%0d", i));

    // Contended owner 1 against requester 3.
    step(4'b0010, e(4'b0010, 2'd1, 1, 1, 0), "pre_grant1");
    for (int i = 1; i <= 3; i++)
      step(4'b1010, e(4'b0010, 2'd1, 1, 1, 0), $sformatf("pre_hold%0d", i));
`ifdef ARB_TIMEOUT_EN
    step(4'b1010, e(4'b0000, 2'd1, 0, 1, 1), "pre_gap_pulse");
    step(4'b1010, e(4'b1000, 2'd3, 1, 1, 0), "pre_grant3");
    step(4'b1000, e(4'b1000, 2'd3, 1, 1, 0), "pre_owner3_a");
    step(4'b1000, e(4'b1000, 2'd3, 1, 1, 0), "pre_owner3_b");
`else
    for (int i = 4; i <= 8; i++)
      step(4'b1010, e(4'b0010, 2'd1, 1, 1, 0), $sformatf("nopre_hold%0d", i));
    step(4'b1000, e(4'b0000, 2'd1, 0, 1, 0), "nopre_gap");
    step(4'b1000, e(4'b1000, 2'd3, 1, 1, 0), "nopre_grant3");
`endif

    // Asynchronous reset in the middle of owner 3's grant.
    #1;
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), e(4'b0000, 2'd0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1001, e(4'b0001, 2'd0, 1, 1, 0), "post_reset_ptr");

    // Uncontended owner keeps the grant.
    step(4'b0010, e(4'b0000, 2'd0, 0, 1, 0), "unc_gap");
    step(4'b0010, e(4'b0010, 2'd1, 1, 1, 0), "unc_grant");
    for (int i = 0; i < 20; i++)
      step(4'b0010, e(4'b0010, 2'd1, 1, 1, 0), $sformatf("unc_hold%0d", i));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
